// File: rtl/pipe_phy_ctrl_responder.sv
// pipe_phy_ctrl_responder: PHY-side responder for the PIPE MAC/PHY control handshakes.
//   Answers power_down, rate and tx_detect_rx requests with one-cycle phy_status
//   completion pulses after parameterised latencies, and reports receiver-detect
//   results on rx_status.
//   clk            : PIPE clock, rising edge
//   reset          : asynchronous active-high reset
//   power_down     : requested power state (0=P0 1=P0s 2=P1 3=P2, others ignored)
//   rate           : requested rate
//   tx_detect_rx   : receiver-detect request level, held until the completion pulse
//   tx_elec_idle   : per-symbol TX electrical idle, bit 0 used
//   rx_present     : detect result to report
//   phy_status     : reset-busy level, then one-cycle completion pulses
//   rx_status      : 3'b011 receiver detected, else 3'b000
//   rx_elec_idle   : high while not in P0
//   busy           : high whenever the FSM is not in IDLE
//   cur_rate       : currently applied rate
//   cur_power_down : currently applied power state
module pipe_phy_ctrl_responder #(
   parameter int RESET_LAT  = 16,
   parameter int DETECT_LAT = 8,
   parameter int RATE_LAT   = 12,
   parameter int PD_LAT     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] power_down,
   input  logic [3:0] rate,
   input  logic       tx_detect_rx,
   input  logic [3:0] tx_elec_idle,
   input  logic       rx_present,
   output logic       phy_status,
   output logic [2:0] rx_status,
   output logic       rx_elec_idle,
   output logic       busy,
   output logic [3:0] cur_rate,
   output logic [3:0] cur_power_down
);
   localparam int M1      = RESET_LAT > DETECT_LAT ? RESET_LAT : DETECT_LAT;
   localparam int M2      = RATE_LAT > PD_LAT ? RATE_LAT : PD_LAT;
   localparam int MAX_LAT = M1 > M2 ? M1 : M2;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic [2:0] {RST_WAIT, IDLE, DETECT, DET_HOLD, RATE, PWR} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d, lat_m1;
   logic [3:0]    tgt, tgt_d, cur_rate_d, cur_pd_d;
   logic          last, pulse, det_hit, pd_legal;
   logic          unused_elec_idle;

   assign unused_elec_idle = ^tx_elec_idle[3:1];
   assign pd_legal         = power_down[3:2] == 2'b00;

   // Terminal count of the running state; expiry lands on the LAT-th edge after entry.
   always_comb begin
      lat_m1 = state == RST_WAIT ? CW'(RESET_LAT - 1) :
               state == DETECT   ? CW'(DETECT_LAT - 1) :
               state == RATE     ? CW'(RATE_LAT - 1) : CW'(PD_LAT - 1);
      last   = cnt == lat_m1;
   end

   always_comb begin
      state_d    = state;
      cnt_d      = '0;
      tgt_d      = tgt;
      cur_rate_d = cur_rate;
      cur_pd_d   = cur_power_down;
      pulse      = 1'b0;
      det_hit    = 1'b0;
      case (state)
         RST_WAIT: begin
            cnt_d = last ? '0 : cnt + CW'(1);
            if (last) begin
               state_d    = IDLE;
               cur_rate_d = rate;
               cur_pd_d   = pd_legal ? power_down : 4'd2;
            end
         end
         IDLE: begin
            // Detect only answers in P1 with TX idle; anywhere else it is a loopback request.
            if (tx_detect_rx && cur_power_down == 4'd2 && tx_elec_idle[0])
               state_d = DETECT;
            else if (rate != cur_rate) begin
               state_d = RATE;
               tgt_d   = rate;
            end else if (pd_legal && power_down != cur_power_down) begin
               state_d = PWR;
               tgt_d   = power_down;
            end
         end
         DETECT: begin
            cnt_d = last ? '0 : cnt + CW'(1);
            if (last) begin
               state_d = DET_HOLD;
               pulse   = 1'b1;
               det_hit = rx_present;
            end
         end
         // Wait for the MAC to drop the request so a held level cannot retrigger.
         DET_HOLD: state_d = tx_detect_rx ? DET_HOLD : IDLE;
         RATE: begin
            cnt_d = last ? '0 : cnt + CW'(1);
            if (last) begin
               state_d    = IDLE;
               pulse      = 1'b1;
               cur_rate_d = tgt;
            end
         end
         PWR: begin
            cnt_d = last ? '0 : cnt + CW'(1);
            if (last) begin
               state_d  = IDLE;
               pulse    = 1'b1;
               cur_pd_d = tgt;
            end
         end
         default: state_d = RST_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state          <= RST_WAIT;
         cnt            <= '0;
         tgt            <= '0;
         phy_status     <= 1'b1;
         rx_status      <= 3'b000;
         rx_elec_idle   <= 1'b1;
         busy           <= 1'b1;
         cur_rate       <= 4'd0;
         cur_power_down <= 4'd2;
      end else begin
         state          <= state_d;
         cnt            <= cnt_d;
         tgt            <= tgt_d;
         phy_status     <= (state == RST_WAIT && !last) || pulse;
         rx_status      <= det_hit ? 3'b011 : 3'b000;
         rx_elec_idle   <= state_d == RST_WAIT || cur_pd_d != 4'd0;
         busy           <= state_d != IDLE;
         cur_rate       <= cur_rate_d;
         cur_power_down <= cur_pd_d;
      end
endmodule
